mem_access_unit: RTL and testbench

Parametrised data-memory access stage for the pipelined RV32I/RV64I core, placed between the EX/MEM register and the D-cache port.
- Generalises the fixed 32-bit, single-cycle store lane logic and load extension.
- Adds a stall/response handshake with the cache, a configurable data width, and split handling of boundary-crossing misaligned accesses.
- Returns load data already aligned and sign/zero-extended for the MEM/WB register.

---
 rtl/mem_access_unit_pkg.sv | 16 +
 rtl/mem_lane_align.sv | 61 ++++++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_unit_pkg: shared types for the data-memory access stage.
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} mau_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_t;

  function automatic logic [31:0] size_bytes(input mem_size_t s);
    return 32'd1 << s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_lane_align: byte-lane masks, store lane shift, load extract/extend.
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                        load_i,
  input  logic                        phase_hi_i,
  input  logic [$clog2(XLEN/8)-1:0]   off_i,
  input  mem_size_t                   size_i,
  input  logic                        unsigned_i,
  input  logic [2*XLEN-1:0]           data_i,
  output logic [XLEN/8-1:0]           mbe_o,
  output logic [XLEN-1:0]             data_o
);

  localparam int NB = XLEN / 8;

  logic [31:0]       bytes;
  logic [2*NB-1:0]   ones;
  logic [2*NB-1:0]   lanes;
  logic [2*XLEN-1:0] st_shift;
  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   ext;
  logic              msb;

  assign bytes = size_bytes(size_i);

  always_comb begin
    ones = '0;
    for (int i = 0; i < 2*NB; i++) begin
      ones[i] = 32'(i) < bytes;
    end
  end

  // Lanes beyond NB belong to the second word of a boundary-crossing access.
  assign lanes    = ones << off_i;
  assign mbe_o    = phase_hi_i ? lanes[2*NB-1:NB] : lanes[NB-1:0];
  assign st_shift = data_i << {off_i, 3'b000};
  assign raw      = XLEN'(data_i >> {off_i, 3'b000});

  always_comb begin
    msb = 1'b0;
    ext = '0;
    for (int i = 0; i < NB; i++) begin
      if (32'(i) + 1 == bytes) msb = raw[8*i+7];
    end
    for (int i = 0; i < NB; i++) begin
      ext[8*i +: 8] = (32'(i) < bytes) ? raw[8*i +: 8] : {8{msb & ~unsigned_i}};
    end
  end

  assign data_o = load_i     ? ext :
                  phase_hi_i ? st_shift[2*XLEN-1:XLEN] : st_shift[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_unit: D-cache access stage with lane alignment and split access.
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic              flush,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              misalign_fault,
  output logic              data_read,
  output logic              data_write,
  output logic [XLEN/8-1:0] data_mbe,
  output logic [ADDR_W-1:0] data_addr,
  output logic [XLEN-1:0]   data_wdata,
  input  logic              data_resp,
  input  logic [XLEN-1:0]   data_rdata
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int          OFF_W = $clog2(NB);

  mau_state_t        state_q;
  logic              read_q, write_q, uns_q, fault_q, cross_q;
  mem_size_t         size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q, lo_buf_q, hi_buf_q;

  mem_size_t         req_size;
  logic [31:0]       req_bytes;
  logic              req_cross, req_illegal, req_fault, accept;
  logic              active, phase_hi, done;
  logic [OFF_W-1:0]  off;
  logic [ADDR_W-1:0] aligned;
  logic [NB-1:0]     st_mbe, ld_mbe;
  logic [XLEN-1:0]   st_data, ld_data;

  assign req_size    = mem_size_t'(req_funct3[1:0]);
  assign req_bytes   = size_bytes(req_size);
  assign req_cross   = (32'(req_addr[OFF_W-1:0]) + req_bytes) > NB;
  assign req_illegal = (req_bytes > NB) | (req_read & req_write);
  assign req_fault   = req_illegal | (req_cross & ~SPLIT_MISALIGNED);
  // Gated by rst so every output reads zero while reset is held.
  assign accept      = (state_q == IDLE) & req_valid & (req_read | req_write) & ~flush & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      uns_q    <= 1'b0;
      fault_q  <= 1'b0;
      cross_q  <= 1'b0;
      size_q   <= SZ_B;
      addr_q   <= '0;
      wdata_q  <= '0;
      lo_buf_q <= '0;
      hi_buf_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          read_q  <= req_read;
          write_q <= req_write;
          uns_q   <= req_funct3[2];
          size_q  <= req_size;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          fault_q <= req_fault;
          cross_q <= req_cross;
          state_q <= req_fault ? DONE : LO;
        end
        LO: if (data_resp) begin
          lo_buf_q <= data_rdata;
          state_q  <= cross_q ? HI : DONE;
        end
        HI: if (data_resp) begin
          hi_buf_q <= data_rdata;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign active   = (state_q == LO) | (state_q == HI);
  assign phase_hi = (state_q == HI);
  assign done     = (state_q == DONE);
  assign off      = addr_q[OFF_W-1:0];
  assign aligned  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  mem_lane_align #(.XLEN(XLEN)) u_store_align (
    .load_i     (1'b0),
    .phase_hi_i (phase_hi),
    .off_i      (off),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_i     ({{XLEN{1'b0}}, wdata_q}),
    .mbe_o      (st_mbe),
    .data_o     (st_data)
  );

  mem_lane_align #(.XLEN(XLEN)) u_load_align (
    .load_i     (1'b1),
    .phase_hi_i (phase_hi),
    .off_i      (off),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_i     ({hi_buf_q, lo_buf_q}),
    .mbe_o      (ld_mbe),
    .data_o     (ld_data)
  );

  assign stall          = accept | active;
  assign data_read      = active & read_q;
  assign data_write     = active & write_q;
  assign data_mbe       = active ? (write_q ? st_mbe : ld_mbe) : '0;
  assign data_addr      = active ? (phase_hi ? aligned + ADDR_W'(NB) : aligned) : '0;
  assign data_wdata     = (active & write_q) ? st_data : '0;
  assign resp_valid     = done;
  assign misalign_fault = done & fault_q;
  assign resp_rdata     = (done & read_q & ~fault_q) ? ld_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_access_unit: directed bench for 32-bit split, 32-bit no-split, 64-bit.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a, req_valid_b, req_valid_c;
  logic        req_read, req_write, flush, data_resp;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, data_rdata;

  logic        a_stall, a_rv, a_fault, a_read, a_write;
  logic [31:0] a_rdata, a_addr, a_wdata;
  logic [3:0]  a_mbe;
  logic        b_stall, b_rv, b_fault, b_read, b_write;
  logic [31:0] b_rdata, b_addr, b_wdata;
  logic [3:0]  b_mbe;
  logic        c_stall, c_rv, c_fault, c_read, c_write;
  logic [63:0] c_rdata, c_wdata;
  logic [31:0] c_addr;
  logic [7:0]  c_mbe;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_read(req_read), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .flush(flush),
    .stall(a_stall), .resp_valid(a_rv), .resp_rdata(a_rdata), .misalign_fault(a_fault),
    .data_read(a_read), .data_write(a_write), .data_mbe(a_mbe), .data_addr(a_addr),
    .data_wdata(a_wdata), .data_resp(data_resp), .data_rdata(data_rdata[31:0]));

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_read(req_read), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .flush(flush),
    .stall(b_stall), .resp_valid(b_rv), .resp_rdata(b_rdata), .misalign_fault(b_fault),
    .data_read(b_read), .data_write(b_write), .data_mbe(b_mbe), .data_addr(b_addr),
    .data_wdata(b_wdata), .data_resp(data_resp), .data_rdata(data_rdata[31:0]));

  mem_access_unit #(.XLEN(64), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut_c (
    .clk(clk), .rst(rst), .req_valid(req_valid_c), .req_read(req_read), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .stall(c_stall), .resp_valid(c_rv), .resp_rdata(c_rdata), .misalign_fault(c_fault),
    .data_read(c_read), .data_write(c_write), .data_mbe(c_mbe), .data_addr(c_addr),
    .data_wdata(c_wdata), .data_resp(data_resp), .data_rdata(data_rdata));

  task automatic drive_req(input logic [2:0] f3, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [63:0] wd);
    req_funct3 = f3; req_read = rd; req_write = wr; req_addr = addr; req_wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid_a = 0; req_valid_b = 0; req_valid_c = 0; flush = 0; data_resp = 0;
    data_rdata = '0; drive_req(3'b000, 1'b0, 1'b0, 32'h0, 64'h0);
    @(negedge clk); #1;
    n_checks++;
    if ({a_stall, a_rv, a_fault, a_read, a_write, a_mbe} !== 9'b0) begin
      n_fail++; $display("FAIL reset_a_ctrl: got %b want 0", {a_stall, a_rv, a_fault, a_read, a_write, a_mbe});
    end
    n_checks++;
    if ({a_addr, a_wdata, a_rdata, c_rdata, c_mbe, b_mbe} !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h c_rdata=%h want 0", a_addr, a_wdata, a_rdata, c_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_store_word();
    @(negedge clk); drive_req(3'b010, 1'b0, 1'b1, 32'h100, 64'hDEADBEEF); req_valid_a = 1; #1;
    n_checks++;
    if ({a_stall, a_write} !== 2'b10) begin
      n_fail++; $display("FAIL sw_accept: got stall,write=%b want 10", {a_stall, a_write});
    end
    @(negedge clk); req_valid_a = 0;
    for (int k = 0; k < 3; k++) begin
      data_resp = (k == 2); #1;
      n_checks++;
      if ({a_stall, a_write, a_rv} !== 3'b110 || a_addr !== 32'h100 || a_mbe !== 4'b1111 || a_wdata !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL sw_lo_cycle%0d: got stall,write,rv=%b addr=%h mbe=%b wdata=%h want 110 100 1111 deadbeef",
                           k, {a_stall, a_write, a_rv}, a_addr, a_mbe, a_wdata);
      end
      @(negedge clk);
    end
    data_resp = 0; #1;
    n_checks++;
    if ({a_rv, a_stall, a_write, a_fault} !== 4'b1000 || a_rdata !== 32'h0) begin
      n_fail++; $display("FAIL sw_done: got rv,stall,write,fault=%b rdata=%h want 1000 0", {a_rv, a_stall, a_write, a_fault}, a_rdata);
    end
    @(negedge clk); #1;
    n_checks++;
    if (a_rv !== 1'b0) begin
      n_fail++; $display("FAIL sw_rv_pulse: got %b want 0", a_rv);
    end
  endtask

  task automatic test_load_single(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] rd, input logic [31:0] exp);
    @(negedge clk); drive_req(f3, 1'b1, 1'b0, addr, 64'h0); req_valid_a = 1;
    @(negedge clk); req_valid_a = 0; data_resp = 1; data_rdata = {32'h0, rd}; #1;
    n_checks++;
    if (a_read !== 1'b1 || a_addr !== {addr[31:2], 2'b00}) begin
      n_fail++; $display("FAIL %s_lo: got read=%b addr=%h want 1 %h", nm, a_read, a_addr, {addr[31:2], 2'b00});
    end
    @(negedge clk); data_resp = 0; #1;
    n_checks++;
    if (a_rv !== 1'b1 || a_rdata !== exp) begin
      n_fail++; $display("FAIL %s_data: got rv=%b rdata=%h want 1 %h", nm, a_rv, a_rdata, exp);
    end
  endtask

  task automatic test_split_load();
    @(negedge clk); drive_req(3'b010, 1'b1, 1'b0, 32'h102, 64'h0); req_valid_a = 1;
    @(negedge clk); req_valid_a = 0; data_resp = 1; data_rdata = 64'hAABBCCDD; #1;
    n_checks++;
    if (a_read !== 1'b1 || a_addr !== 32'h100 || a_mbe !== 4'b1100) begin
      n_fail++; $display("FAIL lw_split_lo: got read=%b addr=%h mbe=%b want 1 100 1100", a_read, a_addr, a_mbe);
    end
    @(negedge clk); data_rdata = 64'h11223344; #1;
    n_checks++;
    if (a_read !== 1'b1 || a_addr !== 32'h104 || a_mbe !== 4'b0011 || {a_stall, a_rv} !== 2'b10) begin
      n_fail++; $display("FAIL lw_split_hi: got read=%b addr=%h mbe=%b stall,rv=%b want 1 104 0011 10",
                         a_read, a_addr, a_mbe, {a_stall, a_rv});
    end
    @(negedge clk); data_resp = 0; #1;
    n_checks++;
    if (a_rv !== 1'b1 || a_rdata !== 32'h3344AABB || a_fault !== 1'b0) begin
      n_fail++; $display("FAIL lw_split_data: got rv=%b rdata=%h fault=%b want 1 3344aabb 0", a_rv, a_rdata, a_fault);
    end
  endtask

  task automatic test_split_store();
    @(negedge clk); drive_req(3'b001, 1'b0, 1'b1, 32'h1FF, 64'hBEEF); req_valid_a = 1;
    @(negedge clk); req_valid_a = 0; data_resp = 1; #1;
    n_checks++;
    if (a_write !== 1'b1 || a_addr !== 32'h1FC || a_mbe !== 4'b1000 || a_wdata !== 32'hEF000000) begin
      n_fail++; $display("FAIL sh_split_lo: got write=%b addr=%h mbe=%b wdata=%h want 1 1fc 1000 ef000000",
                         a_write, a_addr, a_mbe, a_wdata);
    end
    @(negedge clk); #1;
    n_checks++;
    if (a_write !== 1'b1 || a_addr !== 32'h200 || a_mbe !== 4'b0001 || a_wdata !== 32'h000000BE) begin
      n_fail++; $display("FAIL sh_split_hi: got write=%b addr=%h mbe=%b wdata=%h want 1 200 0001 000000be",
                         a_write, a_addr, a_mbe, a_wdata);
    end
    @(negedge clk); data_resp = 0; #1;
    n_checks++;
    if (a_rv !== 1'b1 || a_rdata !== 32'h0 || a_write !== 1'b0) begin
      n_fail++; $display("FAIL sh_split_done: got rv=%b rdata=%h write=%b want 1 0 0", a_rv, a_rdata, a_write);
    end
  endtask

  task automatic test_fault_nosplit();
    @(negedge clk); drive_req(3'b010, 1'b1, 1'b0, 32'h101, 64'h0); req_valid_b = 1; #1;
    n_checks++;
    if ({b_stall, b_read} !== 2'b10) begin
      n_fail++; $display("FAIL nosplit_accept: got stall,read=%b want 10", {b_stall, b_read});
    end
    @(negedge clk); req_valid_b = 0; #1;
    n_checks++;
    if ({b_rv, b_fault, b_read, b_write, b_stall} !== 5'b11000 || b_rdata !== 32'h0 || b_mbe !== 4'h0) begin
      n_fail++; $display("FAIL nosplit_fault: got rv,fault,read,write,stall=%b rdata=%h mbe=%b want 11000 0 0",
                         {b_rv, b_fault, b_read, b_write, b_stall}, b_rdata, b_mbe);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({b_rv, b_fault, b_addr, b_wdata} !== '0) begin
      n_fail++; $display("FAIL nosplit_after: got rv=%b fault=%b addr=%h want 0", b_rv, b_fault, b_addr);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk); drive_req(3'b011, 1'b1, 1'b0, 32'h100, 64'h0); req_valid_a = 1;
    @(negedge clk); req_valid_a = 0; #1;
    n_checks++;
    if ({a_rv, a_fault, a_read} !== 3'b110 || a_rdata !== 32'h0) begin
      n_fail++; $display("FAIL ld_on_rv32: got rv,fault,read=%b rdata=%h want 110 0", {a_rv, a_fault, a_read}, a_rdata);
    end
    @(negedge clk); drive_req(3'b010, 1'b1, 1'b1, 32'h100, 64'h0); req_valid_a = 1;
    @(negedge clk); req_valid_a = 0; #1;
    n_checks++;
    if ({a_rv, a_fault, a_read, a_write} !== 4'b1100) begin
      n_fail++; $display("FAIL rd_and_wr: got rv,fault,read,write=%b want 1100", {a_rv, a_fault, a_read, a_write});
    end
  endtask

  task automatic test_flush();
    @(negedge clk); drive_req(3'b010, 1'b1, 1'b0, 32'h100, 64'h0); req_valid_a = 1; flush = 1; #1;
    n_checks++;
    if (a_stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall: got %b want 0", a_stall);
    end
    @(negedge clk); req_valid_a = 0; flush = 0; #1;
    n_checks++;
    if ({a_read, a_rv, a_stall} !== 3'b000) begin
      n_fail++; $display("FAIL flush_no_access: got read,rv,stall=%b want 000", {a_read, a_rv, a_stall});
    end
  endtask

  task automatic test_reset_mid_then_64();
    @(negedge clk); drive_req(3'b010, 1'b1, 1'b0, 32'h100, 64'h0); req_valid_a = 1;
    @(negedge clk); req_valid_a = 0; #1;
    n_checks++;
    if (a_read !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got read=%b want 1", a_read);
    end
    rst = 1'b1; #1;
    n_checks++;
    if ({a_read, a_stall, a_rv, a_mbe, a_addr} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got read=%b stall=%b mbe=%b addr=%h want 0", a_read, a_stall, a_mbe, a_addr);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({a_read, a_rv, a_stall} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_abandon: got read,rv,stall=%b want 000", {a_read, a_rv, a_stall});
    end
    drive_req(3'b011, 1'b1, 1'b0, 32'h8, 64'h0); req_valid_c = 1; #1;
    n_checks++;
    if (c_stall !== 1'b1) begin
      n_fail++; $display("FAIL ld64_accept: got stall=%b want 1", c_stall);
    end
    @(negedge clk); req_valid_c = 0; data_resp = 1; data_rdata = 64'h8123456789ABCDEF; #1;
    n_checks++;
    if (c_read !== 1'b1 || c_mbe !== 8'hFF || c_addr !== 32'h8 || c_write !== 1'b0 || c_wdata !== 64'h0) begin
      n_fail++; $display("FAIL ld64_lo: got read=%b mbe=%h addr=%h write=%b want 1 ff 8 0", c_read, c_mbe, c_addr, c_write);
    end
    @(negedge clk); data_resp = 0; #1;
    n_checks++;
    if ({c_rv, c_read, c_fault} !== 3'b100 || c_rdata !== 64'h8123456789ABCDEF) begin
      n_fail++; $display("FAIL ld64_data: got rv,read,fault=%b rdata=%h want 100 8123456789abcdef", {c_rv, c_read, c_fault}, c_rdata);
    end
    @(negedge clk); drive_req(3'b010, 1'b1, 1'b0, 32'hC, 64'h0); req_valid_c = 1;
    @(negedge clk); req_valid_c = 0; data_resp = 1; data_rdata = 64'h80000000_00000000; #1;
    n_checks++;
    if (c_mbe !== 8'hF0 || c_addr !== 32'h8) begin
      n_fail++; $display("FAIL lw64_lo: got mbe=%h addr=%h want f0 8", c_mbe, c_addr);
    end
    @(negedge clk); data_resp = 0; #1;
    n_checks++;
    if (c_rv !== 1'b1 || c_rdata !== 64'hFFFFFFFF_80000000) begin
      n_fail++; $display("FAIL lw64_sext: got rv=%b rdata=%h want 1 ffffffff80000000", c_rv, c_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_single("lb",  3'b000, 32'h203, 32'h80112233, 32'hFFFFFF80);
    test_load_single("lbu", 3'b100, 32'h203, 32'h80112233, 32'h00000080);
    test_load_single("lhu", 3'b101, 32'h202, 32'h80112233, 32'h00008011);
    test_split_load();
    test_split_store();
    test_fault_nosplit();
    test_illegal();
    test_flush();
    test_reset_mid_then_64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
